// File: rtl/hazard_scoreboard_unit.sv
// Stall/flush control for hazards forwarding cannot resolve: load-use, long-op RAW/WAW,
// single-outstanding MUL/DIV occupancy and taken-branch flushes.
module hazard_scoreboard_unit #(
    parameter int REG_W   = 5,
    parameter int MAX_LAT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1_D,
    input  logic [REG_W-1:0] Rs2_D,
    input  logic [REG_W-1:0] RD_D,
    input  logic             RegWriteD,
    input  logic             LongOpD,
    input  logic [REG_W-1:0] RD_E,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             LongDoneW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             LongBusy,
    output logic             ProtoErr
);
    // state | meaning
    // IDLE  | no long op in flight, MUL/DIV unit free
    // BUSY  | one long op in flight, long_rd holds its destination
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int NREG  = 1 << REG_W;
    localparam int LAT_W = $clog2(MAX_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

    state_t            state, state_nxt;
    logic [NREG-1:0]   pending, pending_nxt, pend_eff;
    logic [REG_W-1:0]  long_rd, long_rd_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic              err, err_nxt;
    logic              done_ok, lw_stall, raw_stall, waw_stall, st_stall, stall, issue;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            long_rd <= '0;
            lat_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            long_rd <= long_rd_nxt;
            lat_cnt <= lat_nxt;
            err     <= err_nxt;
        end
    end

    // A completing op releases its register in the same cycle so dependents need not wait an extra cycle.
    always_comb begin
        done_ok   = LongDoneW & (state == BUSY);
        pend_eff  = pending;
        if (done_ok)
            pend_eff[long_rd] = 1'b0;
        lw_stall  = LoadE & (RD_E != '0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));
        raw_stall = pend_eff[Rs1_D] | pend_eff[Rs2_D];
        waw_stall = RegWriteD & pend_eff[RD_D];
        st_stall  = LongOpD & (state == BUSY) & ~done_ok;
        stall     = lw_stall | raw_stall | waw_stall | st_stall;
        issue     = LongOpD & ~stall & ~PCSrcE;
    end

    always_comb begin
        state_nxt   = state;
        long_rd_nxt = long_rd;
        lat_nxt     = lat_cnt;
        err_nxt     = err;
        pending_nxt = pend_eff;
        if (issue && RegWriteD && (RD_D != '0))
            pending_nxt[RD_D] = 1'b1;
        pending_nxt[0] = 1'b0;
        case (state)
            IDLE: begin
                if (LongDoneW)
                    err_nxt = 1'b1;
                if (issue) begin
                    state_nxt   = BUSY;
                    long_rd_nxt = RD_D;
                    lat_nxt     = '0;
                end
            end
            BUSY: begin
                if (lat_cnt == LAT_MAX)
                    err_nxt = 1'b1;
                if (issue) begin
                    long_rd_nxt = RD_D;
                    lat_nxt     = '0;
                end else if (done_ok) begin
                    state_nxt = IDLE;
                    lat_nxt   = '0;
                end else if (lat_cnt != LAT_MAX) begin
                    lat_nxt = lat_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        StallF   = rst_n & stall;
        StallD   = rst_n & stall;
        FlushD   = rst_n & PCSrcE;
        FlushE   = rst_n & (stall | PCSrcE);
        LongBusy = rst_n & (state == BUSY);
        ProtoErr = rst_n & err;
    end
endmodule
